// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner. Each digit slot starts with a
// blanking gap, and the input patterns are frozen once per frame.
module seg_scan #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       Clk100M,
    input  logic       reset_n,
    input  logic [7:0] seg0,
    input  logic [7:0] seg1,
    input  logic [7:0] seg2,
    input  logic [7:0] seg3,
    input  logic       disp_en,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       frame_done
);

    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0]   cnt, cnt_nx;
    logic [1:0]      idx, idx_nx;
    logic [3:0][7:0] sh, seg_in;
    logic            slot_end, frame_start, drive_nx;

    assign seg_in = {seg3, seg2, seg1, seg0};

    // Output decode works on the post-edge slot position, so outputs land in
    // the same cycle as the counter state they describe.
    always_comb begin
        slot_end    = (cnt == CNT_LAST);
        cnt_nx      = slot_end ? '0 : cnt + CW'(1);
        idx_nx      = idx + {1'b0, slot_end};
        frame_start = (cnt == '0) && (idx == 2'd0);
        drive_nx    = (cnt_nx >= CNT_BLANK) && disp_en;
    end

    always_ff @(posedge Clk100M or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else begin
            cnt <= cnt_nx;
            idx <= idx_nx;
        end
    end

    // Shadows load on the first cycle of a frame, which is always blank, so a
    // digit never shows a half-updated frame.
    always_ff @(posedge Clk100M or negedge reset_n) begin
        if (!reset_n)
            sh <= {4{8'hFF}};
        else if (frame_start)
            sh <= seg_in;
    end

    always_ff @(posedge Clk100M or negedge reset_n) begin
        if (!reset_n) begin
            an         <= 4'hF;
            seg        <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            an         <= drive_nx ? ~(4'b0001 << idx_nx) : 4'hF;
            seg        <= drive_nx ? sh[idx_nx] : 8'hFF;
            frame_done <= slot_end && (idx == 2'd3);
        end
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed four-digit seven-segment scanner sitting directly downstream of the game-play stage. It takes the four per-digit segment patterns (seg0..seg3) and drives the shared seg bus and the an digit enables one digit at a time. Each digit slot starts with an inter-digit blanking gap to suppress ghosting. Inputs are frozen once per frame so a displayed frame is always internally consistent.

## Interface
- DIGIT_CYCLES, 100000: clock cycles per digit slot, blank plus drive (1 ms at 100 MHz).
- BLANK_CYCLES, 1000: blanking cycles at the start of each slot; legal range 2 <= BLANK_CYCLES < DIGIT_CYCLES.
- Clk100M  input  1  system clock, 100 MHz; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- seg0  input  8  digit 0 pattern (rightmost digit); active-low segments, bit 7 = dp.
- seg1  input  8  digit 1 pattern.
- seg2  input  8  digit 2 pattern.
- seg3  input  8  digit 3 pattern (leftmost digit).
- disp_en  input  1  display enable; low forces blank outputs while scanning continues.
- seg  output  8  registered, active-low segment bus.
- an  output  4  registered, active-low digit enables; an[k] selects digit k.
- frame_done  output  1  registered one-cycle pulse at each frame wrap.

## Operation
- State:
  - slot counter cnt, 0..DIGIT_CYCLES-1, width clog2(DIGIT_CYCLES);
  - digit index idx, 2 bits;
  - four 8-bit shadow registers sh0..sh3.
- Reset (async, immediate): cnt=0, idx=0, sh0..sh3=8'hFF, an=4'b1111, seg=8'hFF, frame_done=0.
- Every rising edge advances the slot counter:
  - if cnt==DIGIT_CYCLES-1, then cnt->0 and idx->idx+1, wrapping 3->0;
  - otherwise cnt->cnt+1.
- Phase is a function of the post-edge cnt:
  - cnt < BLANK_CYCLES: BLANK phase;
  - otherwise: DRIVE phase.
- Output registers load each edge from the post-edge state:
  - BLANK phase, or disp_en low (sampled at that edge): an=4'b1111, seg=8'hFF;
  - DRIVE phase with disp_en high: an = all ones except bit idx low; seg = sh[idx].
- Shadow capture:
  - sh0..sh3 load seg0..seg3 on each edge whose pre-edge state is idx=0, cnt=0 (first cycle of a frame, including the first edge after reset);
  - shadows hold for the rest of the frame, so input changes after that edge appear only in the next frame.
- frame_done is 1 for exactly the cycle after the edge where idx wraps 3->0, and 0 otherwise.
- At most one bit of an is ever low.
- disp_en never affects cnt, idx, shadows or frame_done.

## Timing
- Rising edges after reset release are numbered 1, 2, ...
- Frame period is 4*DIGIT_CYCLES. Digit k (k=0..3) in the frame starting at edge F (first frame F=0):
  - blank from edge F+k*D;
  - driven from edge F+k*D+B through F+(k+1)*D-1;
  - D = DIGIT_CYCLES, B = BLANK_CYCLES.
- Each digit is driven for D-B cycles; the blanking gap between digits is B cycles.
- Shadow load (edge F+1) precedes the first digit-0 drive (edge F+B), since B >= 2.
- frame_done is high on the cycles following edges 4D, 8D, ...
- disp_en latency: one edge to blank and one edge to restore; restore lands on the current digit if still in DRIVE.
- Reset asserted mid-slot:
  - outputs blank and frame_done clears without waiting for a clock edge;
  - after release, the sequence restarts exactly as from power-up.

## Test plan
Bench parameters: DIGIT_CYCLES=6, BLANK_CYCLES=2, disp_en=1 unless stated.

1. Power-up frame: seg0=C0, seg1=F9, seg2=A4, seg3=B0; release reset_n.
   - an=1111 through edge 1;
   - edge 2..5: an=1110, seg=C0;
   - edge 6..7: blank;
   - edge 8..11: an=1101, seg=F9;
   - edge 14: an=1011, seg=A4;
   - edge 20: an=0111, seg=B0;
   - frame_done=1 only after edge 24.
2. Mid-frame input change: set seg1=99 before edge 5 of the first frame.
   - digit 1 shows F9 at edge 8;
   - digit 1 shows 99 at edge 32.
3. Display enable: disp_en sampled low at edges 9-10, high from edge 11.
   - an=1111, seg=FF after edges 9 and 10;
   - an=1101, seg=F9 restored at edge 11;
   - frame_done still after edge 24.
4. Async reset mid-drive: drop reset_n between edges 15 and 16.
   - an=1111, seg=FF, frame_done=0 immediately, before the next edge;
   - after release, scenario 1 timing repeats exactly.
5. Default parameters, long run of 3 frames.
   - frame_done spacing is 400000 cycles;
   - each digit is low on an for 99000 consecutive cycles;
   - gaps of 1000 all-high cycles between digits;
   - an never has two low bits.
6. Wrap continuity: run 2 frames with static inputs.
   - edges 24..49 reproduce edges 0..25 offset by 24;
   - idx wraps 3->0 with no extra blank cycles.
